// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin burst reader over NUM_CH line FIFOs feeding one valid/ready pixel stream
module fifo_rd_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 64,
  parameter int CNT_W     = 7,
  parameter int CH_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_CH-1:0]        ch_empty,
  output logic [NUM_CH-1:0]        ch_rd_en,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_dout,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_data,
  output logic [CH_W-1:0]          m_ch,
  output logic                     m_last,
  output logic                     burst_done,
  output logic [CNT_W-1:0]         burst_cnt,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, ARB, BURST, DRAIN} state_t;
  state_t state, state_n;
  logic [CH_W-1:0] rr_ptr, grant, grant_d, pick, cand;
  logic [CNT_W-1:0] count;
  logic hit, rd_go, full_hit, credit, inflight, last_d, done_c, push, pop;
  logic [1:0] occ;
  logic wp, rp;
  logic [DATA_W-1:0] buf_data [2];
  logic [CH_W-1:0]   buf_ch   [2];
  logic              buf_last [2];

  // scan from farthest to nearest so the nearest non-empty channel after rr_ptr wins
  always_comb begin
    hit = 1'b0;
    pick = '0;
    cand = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!ch_empty[cand]) begin
        hit = 1'b1;
        pick = cand;
      end
    end
  end

  assign credit   = (occ + 2'(inflight)) < 2'd2;
  assign rd_go    = (state == BURST) && !ch_empty[grant] && credit;
  assign full_hit = rd_go && (count == CNT_W'(BURST_LEN - 1));
  assign ch_rd_en = rd_go ? (NUM_CH'(1) << grant) : '0;

  always_comb begin
    state_n = state;
    done_c = 1'b0;
    case (state)
      IDLE:  state_n = enable ? ARB : IDLE;
      ARB:   state_n = !enable ? IDLE : (hit ? BURST : ARB);
      BURST: state_n = (full_hit || ch_empty[grant]) ? DRAIN : BURST;
      DRAIN: begin
        done_c = !inflight;
        state_n = inflight ? DRAIN : (enable ? ARB : IDLE);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= CH_W'(NUM_CH - 1);
      grant <= '0;
      grant_d <= '0;
      count <= '0;
      inflight <= 1'b0;
      last_d <= 1'b0;
      burst_done <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state <= state_n;
      inflight <= rd_go;
      grant_d <= grant;
      last_d <= full_hit;
      burst_done <= done_c;
      if (state == ARB && enable && hit) begin
        grant <= pick;
        count <= '0;
      end else if (rd_go) begin
        count <= count + 1'b1;
      end
      if (done_c) begin
        burst_cnt <= count;
        rr_ptr <= grant;
      end
    end
  end

  // two-entry ring; the read credit guarantees a push never finds it full
  assign push = inflight && ch_valid[grant_d];
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_ch[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_data[wp] <= ch_dout[int'(grant_d)*DATA_W +: DATA_W];
        buf_ch[wp] <= grant_d;
        buf_last[wp] <= last_d;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  assign m_valid = occ != 2'd0;
  assign m_data  = buf_data[rp];
  assign m_ch    = buf_ch[rp];
  assign m_last  = buf_last[rp];
  assign busy    = (state == BURST) || (state == DRAIN) || (occ != 2'd0);
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb_fifo_rd_arbiter: FIFO-bank model plus scoreboard of expected words and burst lengths
module tb_fifo_rd_arbiter;
  localparam int NUM_CH = 4, DATA_W = 16, BURST_LEN = 64, CNT_W = 7, CH_W = 2;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, m_ready = 1'b1;
  logic [NUM_CH-1:0] ch_empty = '1, ch_valid = '0, ch_rd_en;
  logic [NUM_CH*DATA_W-1:0] ch_dout = '0;
  logic m_valid, m_last, burst_done, busy;
  logic [DATA_W-1:0] m_data;
  logic [CH_W-1:0] m_ch;
  logic [CNT_W-1:0] burst_cnt;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CH_W-1:0] c;
    logic l;
  } exp_t;

  exp_t exp_q[$];
  int bc_q[$];
  logic [DATA_W-1:0] fq[NUM_CH][$];
  int pend_n[NUM_CH];
  int seq[NUM_CH];
  int checks = 0, failures = 0, acc = 0, occ_tb = 0;
  logic load_go = 1'b0, rand_ready = 1'b0, prev_stall = 1'b0;
  logic [DATA_W-1:0] pd;
  logic [CH_W-1:0] pc;
  logic pl;
  exp_t e_m;
  int b_m;

  fifo_rd_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_empty(ch_empty), .ch_rd_en(ch_rd_en),
    .ch_valid(ch_valid), .ch_dout(ch_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_ch(m_ch), .m_last(m_last), .burst_done(burst_done),
    .burst_cnt(burst_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(int c, int k);
    return DATA_W'((c << 12) | (k & 'hfff));
  endfunction

  // line FIFOs with a registered one-cycle read
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) fq[c].delete();
      ch_valid <= '0;
      ch_empty <= '1;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        ch_valid[c] <= ch_rd_en[c];
        if (ch_rd_en[c] && fq[c].size() > 0) ch_dout[c*DATA_W +: DATA_W] <= fq[c].pop_front();
        if (load_go) for (int k = 0; k < pend_n[c]; k++) fq[c].push_back(word(c, seq[c] + k));
        ch_empty[c] <= fq[c].size() == 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      occ_tb = 0;
      prev_stall = 1'b0;
    end else begin
      if (ch_rd_en != '0) begin
        checks++;
        if ((ch_rd_en & ch_empty) != '0 || occ_tb + int'(|ch_valid) >= 2 || $countones(ch_rd_en) != 1) begin
          failures++;
          $display("FAIL rd_en_credit: rd_en=%b empty=%b occ=%0d inflight=%0d required one-hot on non-empty with occ+inflight<2",
                   ch_rd_en, ch_empty, occ_tb, int'(|ch_valid));
        end
      end
      checks++;
      if (m_valid !== (occ_tb > 0)) begin
        failures++;
        $display("FAIL m_valid: got %b required %b", m_valid, occ_tb > 0);
      end
      if (prev_stall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_ch !== pc || m_last !== pl) begin
          failures++;
          $display("FAIL stall_hold: got v=%b d=%h ch=%0d l=%b required v=1 d=%h ch=%0d l=%b", m_valid, m_data, m_ch, m_last, pd, pc, pl);
        end
      end
      if (m_valid && m_ready) begin
        acc++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL word: got unexpected d=%h ch=%0d required no word", m_data, m_ch);
        end else begin
          e_m = exp_q.pop_front();
          if (m_data !== e_m.d || m_ch !== e_m.c || m_last !== e_m.l) begin
            failures++;
            $display("FAIL word: got d=%h ch=%0d last=%b required d=%h ch=%0d last=%b", m_data, m_ch, m_last, e_m.d, e_m.c, e_m.l);
          end
        end
      end
      if (burst_done) begin
        checks++;
        if (bc_q.size() == 0) begin
          failures++;
          $display("FAIL burst_done: got unexpected pulse cnt=%0d required none", burst_cnt);
        end else begin
          b_m = bc_q.pop_front();
          if (burst_cnt !== CNT_W'(b_m)) begin
            failures++;
            $display("FAIL burst_cnt: got %0d required %0d", burst_cnt, b_m);
          end
        end
      end
      occ_tb = occ_tb + int'(|ch_valid) - int'(m_valid && m_ready);
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pc = m_ch;
      pl = m_last;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic add(int c, int n, int nexp);
    exp_t e;
    pend_n[c] = n;
    for (int k = 0; k < nexp; k++) begin
      e.d = word(c, seq[c] + k);
      e.c = CH_W'(c);
      e.l = (k % BURST_LEN) == BURST_LEN - 1;
      exp_q.push_back(e);
    end
    for (int r = nexp; r > 0; r -= BURST_LEN) bc_q.push_back(r > BURST_LEN ? BURST_LEN : r);
  endtask

  task automatic commit();
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      seq[c] += pend_n[c];
      pend_n[c] = 0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    bc_q.delete();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bc_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bc_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got words_left=%0d bursts_left=%0d required 0 and 0", name, exp_q.size(), bc_q.size());
    end
  endtask

  task automatic wait_acc(int target);
    int n = 0;
    while (acc < target && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (acc < target) begin
      failures++;
      $display("FAIL wait_words: got %0d required %0d", acc, target);
    end
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({ch_rd_en, m_valid, m_data, m_ch, m_last, burst_done, burst_cnt, busy} !== '0) begin
      failures++;
      $display("FAIL %s: got rd_en=%b v=%b d=%h ch=%0d l=%b done=%b cnt=%0d busy=%b required all 0",
               name, ch_rd_en, m_valid, m_data, m_ch, m_last, burst_done, burst_cnt, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    check_zero("reset_values");
    rst = 1'b0;
    enable = 1'b1;
    tick(5);
    checks++;
    if (busy !== 1'b0 || ch_rd_en !== '0) begin
      failures++;
      $display("FAIL idle_arb: got busy=%b rd_en=%b required 0 and 0", busy, ch_rd_en);
    end
  endtask

  task automatic test_single_channel();
    add(2, 200, 200);
    commit();
    wait_drain("single_ch2", 3000);
  endtask

  task automatic test_all_channels();
    do_reset();
    for (int c = 0; c < NUM_CH; c++) add(c, 64, 64);
    commit();
    wait_drain("all_channels", 4000);
  endtask

  task automatic test_backpressure();
    do_reset();
    rand_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) add(c, 64, 64);
    commit();
    wait_drain("backpressure", 8000);
    rand_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_refill();
    logic found = 1'b0;
    add(1, 10, 10);
    add(2, 5, 5);
    commit();
    for (int n = 0; n < 300 && !found; n++) begin
      if (ch_empty[1]) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL refill_wait: got ch1 never empty required empty after 10 reads");
    end
    add(1, 6, 6);
    commit();
    wait_drain("refill", 2000);
  endtask

  task automatic test_reset_mid_burst();
    logic [NUM_CH-1:0] first = '0;
    add(0, 64, 64);
    commit();
    wait_acc(acc + 30);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    bc_q.delete();
    #1;
    check_zero("reset_mid_burst");
    tick(2);
    rst = 1'b0;
    for (int c = 0; c < NUM_CH; c++) add(c, 3, 3);
    commit();
    for (int n = 0; n < 50 && first == '0; n++) begin
      first = ch_rd_en;
      if (first == '0) tick();
    end
    checks++;
    if (first !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant: got rd_en=%b required 0001", first);
    end
    wait_drain("after_reset", 2000);
  endtask

  task automatic test_enable_drop();
    int n = 0;
    logic rd_seen = 1'b0;
    add(3, 100, 64);
    commit();
    wait_acc(acc + 20);
    enable = 1'b0;
    while (bc_q.size() != 0 && n < 1000) begin
      tick();
      n++;
    end
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || exp_q.size() != 0 || bc_q.size() != 0) begin
      failures++;
      $display("FAIL enable_drop_end: got busy=%b m_valid=%b words_left=%0d bursts_left=%0d required 0 0 0 0",
               busy, m_valid, exp_q.size(), bc_q.size());
    end
    repeat (30) begin
      tick();
      if (ch_rd_en != '0) rd_seen = 1'b1;
    end
    checks++;
    if (rd_seen !== 1'b0 || ch_empty[3] !== 1'b0) begin
      failures++;
      $display("FAIL enable_drop_idle: got rd_seen=%b ch3_empty=%b required 0 and 0", rd_seen, ch_empty[3]);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_all_channels();
    test_backpressure();
    test_refill();
    test_reset_mid_burst();
    test_enable_drop();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end
endmodule
